switch_alloc_rr: RTL and testbench

// - Wormhole switch allocator for the 5-port router (L,N,E,S,W).
// - Drives the 3-bit crossbar select code of every output.
// - Shares each output between the inputs that request it, using per-output round-robin.
// - Once granted, an output is held by its input from head flit to tail flit.
// - Flits are only granted when the downstream buffer has a credit.

---
 rtl/switch_alloc_rr.sv | 165 ++++++++++++++++
 tb/tb_switch_alloc_rr.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr
//   Wormhole switch allocator for a 5-port router (L,N,E,S,W).
//   Each output is shared between the inputs that request it through a
//   per-output round-robin arbiter. Once an input wins an output, it holds
//   the output from its head flit to its tail flit. A flit is only granted
//   while the downstream buffer of that output has a credit.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   in_valid    [i]        flit present at input i (0=L 1=N 2=E 3=S 4=W)
//   in_dest     [3i+2:3i]  destination output code of input i (5..7 match nothing)
//   in_tail     [i]        flit at input i is a tail flit
//   credit_ret  [o]        downstream returns one credit for output o
//   grant       [i]        flit of input i is transferred this cycle (combinational)
//   sel         [3o+2:3o]  registered crossbar select of output o, 7 = idle
//   credit_err             sticky: credit returned to a full counter
//
// Per-output FSM
//   state     | meaning
//   ST_IDLE   | no owner; arbitrate among requesters, allocate at the edge
//   ST_LOCKED | owned by input r_sel[o] until its tail flit is transferred
module switch_alloc_rr #(
  parameter int N_BIT_SEL    = 3,
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_W        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             in_valid,
  input  logic [5*N_BIT_SEL-1:0] in_dest,
  input  logic [4:0]             in_tail,
  input  logic [4:0]             credit_ret,
  output logic [4:0]             grant,
  output logic [5*N_BIT_SEL-1:0] sel,
  output logic                   credit_err
);

  localparam int                   NP          = 5;
  localparam logic [N_BIT_SEL-1:0] SEL_IDLE    = '1;
  localparam logic [N_BIT_SEL-1:0] PTR_RESET   = N_BIT_SEL'(NP - 1);
  localparam logic [CNT_W-1:0]     CREDIT_FULL = CNT_W'(CREDIT_DEPTH);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               r_state      [NP];
  state_t               w_state_nxt  [NP];
  // While locked, r_sel[o] doubles as the owner index of output o.
  logic [N_BIT_SEL-1:0] r_sel        [NP];
  logic [N_BIT_SEL-1:0] w_sel_nxt    [NP];
  logic [N_BIT_SEL-1:0] r_ptr        [NP];
  logic [N_BIT_SEL-1:0] w_ptr_nxt    [NP];
  logic [CNT_W-1:0]     r_credit     [NP];
  logic [CNT_W-1:0]     w_credit_nxt [NP];
  logic                 r_credit_err;
  logic                 w_credit_err_nxt;

  logic [NP-1:0] w_out_gnt;
  logic [NP-1:0] w_out_tail;
  logic [NP-1:0] w_grant;

  // Transfers: a locked output passes its owner's flit when a credit is left.
  always_comb begin : grant_logic
    w_out_gnt  = '0;
    w_out_tail = '0;
    w_grant    = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (r_state[o] == ST_LOCKED && r_sel[o] == N_BIT_SEL'(i) &&
            in_valid[i] && r_credit[o] != '0) begin
          w_out_gnt[o]  = 1'b1;
          w_out_tail[o] = in_tail[i];
          w_grant[i]    = 1'b1;
        end
      end
    end
  end

  assign grant = rst ? w_grant : '0;

  always_comb begin : next_state
    logic                 found;
    logic [N_BIT_SEL-1:0] win;
    int                   idx;
    w_credit_err_nxt = r_credit_err;
    for (int o = 0; o < NP; o++) begin
      w_state_nxt[o]  = r_state[o];
      w_sel_nxt[o]    = r_sel[o];
      w_ptr_nxt[o]    = r_ptr[o];
      w_credit_nxt[o] = r_credit[o];
      found           = 1'b0;
      win             = SEL_IDLE;
      idx             = 0;

      case (r_state[o])
        ST_IDLE: begin
          // Round-robin search starts just after the last winner.
          for (int k = 1; k <= NP; k++) begin
            idx = (int'(r_ptr[o]) + k) % NP;
            if (!found && in_valid[idx] &&
                in_dest[N_BIT_SEL*idx +: N_BIT_SEL] == N_BIT_SEL'(o)) begin
              found = 1'b1;
              win   = N_BIT_SEL'(idx);
            end
          end
          if (found) begin
            w_state_nxt[o] = ST_LOCKED;
            w_sel_nxt[o]   = win;
            w_ptr_nxt[o]   = win;
          end else begin
            w_sel_nxt[o]   = SEL_IDLE;
          end
        end
        ST_LOCKED: begin
          if (w_out_gnt[o] && w_out_tail[o]) begin
            w_state_nxt[o] = ST_IDLE;
            w_sel_nxt[o]   = SEL_IDLE;
          end
        end
        default: ;
      endcase

      // A grant and a return in the same cycle cancel out.
      if (w_out_gnt[o] && !credit_ret[o]) begin
        w_credit_nxt[o] = r_credit[o] - CNT_W'(1);
      end else if (credit_ret[o] && !w_out_gnt[o]) begin
        if (r_credit[o] == CREDIT_FULL) begin
          w_credit_err_nxt = 1'b1;
        end else begin
          w_credit_nxt[o] = r_credit[o] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        r_state[o]  <= ST_IDLE;
        r_sel[o]    <= SEL_IDLE;
        r_ptr[o]    <= PTR_RESET;
        r_credit[o] <= CREDIT_FULL;
      end
      r_credit_err <= 1'b0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        r_state[o]  <= w_state_nxt[o];
        r_sel[o]    <= w_sel_nxt[o];
        r_ptr[o]    <= w_ptr_nxt[o];
        r_credit[o] <= w_credit_nxt[o];
      end
      r_credit_err <= w_credit_err_nxt;
    end
  end

  always_comb begin
    sel = '0;
    for (int o = 0; o < NP; o++) begin
      sel[N_BIT_SEL*o +: N_BIT_SEL] = r_sel[o];
    end
  end

  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_switch_alloc_rr.sv
// tb_switch_alloc_rr
//   Directed scenarios for the allocator followed by a randomized packet
//   run, all compared cycle by cycle against a behavioural model that keeps
//   owner/pointer/credit per output as plain integers.
module tb_switch_alloc_rr;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_valid;
  logic [14:0] in_dest;
  logic [4:0]  in_tail;
  logic [4:0]  credit_ret;
  logic [4:0]  grant;
  logic [14:0] sel;
  logic        credit_err;

  switch_alloc_rr #(.N_BIT_SEL(3), .CREDIT_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_dest    (in_dest),
    .in_tail    (in_tail),
    .credit_ret (credit_ret),
    .grant      (grant),
    .sel        (sel),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_err    = 0;
  int n_checks = 0;

  // model: owner -1 means the output is idle
  int m_owner  [5];
  int m_ptr    [5];
  int m_credit [5];
  bit m_err;

  logic [4:0]  obs_grant;
  logic [14:0] obs_sel;
  logic        obs_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] dst(input int l, input int n, input int e, input int s, input int w);
    logic [14:0] r;
    r = {3'(w), 3'(s), 3'(e), 3'(n), 3'(l)};
    return r;
  endfunction

  function automatic logic [4:0] model_grant(input logic [4:0] v);
    logic [4:0] g;
    g = '0;
    for (int o = 0; o < 5; o++)
      if (m_owner[o] >= 0 && v[m_owner[o]] && m_credit[o] > 0) g[m_owner[o]] = 1'b1;
    return g;
  endfunction

  function automatic logic [14:0] model_sel();
    logic [14:0] s;
    for (int o = 0; o < 5; o++)
      s[3*o +: 3] = (m_owner[o] < 0) ? 3'd7 : 3'(m_owner[o]);
    return s;
  endfunction

  task automatic model_update(input logic rv, input logic [4:0] v, input logic [14:0] d,
                              input logic [4:0] t, input logic [4:0] cr);
    bit xfer [5];
    if (!rv) begin
      for (int o = 0; o < 5; o++) begin
        m_owner[o]  = -1;
        m_ptr[o]    = 4;
        m_credit[o] = DEPTH;
      end
      m_err = 1'b0;
      return;
    end
    for (int o = 0; o < 5; o++)
      xfer[o] = (m_owner[o] >= 0) && v[m_owner[o]] && (m_credit[o] > 0);
    for (int o = 0; o < 5; o++) begin
      if (m_owner[o] >= 0) begin
        if (xfer[o] && t[m_owner[o]]) m_owner[o] = -1;
      end else begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
          int c;
          c = (m_ptr[o] + k) % 5;
          if (!found && v[c] && int'(d[3*c +: 3]) == o) begin
            found      = 1'b1;
            m_owner[o] = c;
            m_ptr[o]   = c;
          end
        end
      end
      if (xfer[o] && !cr[o]) m_credit[o]--;
      else if (cr[o] && !xfer[o]) begin
        if (m_credit[o] == DEPTH) m_err = 1'b1;
        else m_credit[o]++;
      end
    end
  endtask

  task automatic drive_cycle(input logic rv, input logic [4:0] v, input logic [14:0] d,
                             input logic [4:0] t, input logic [4:0] cr);
    logic [4:0] eg;
    @(negedge clk);
    rst = rv; in_valid = v; in_dest = d; in_tail = t; credit_ret = cr;
    #1;
    n_vec++;
    eg = rv ? model_grant(v) : 5'b0;
    obs_grant = grant;
    obs_sel   = sel;
    obs_err   = credit_err;
    chk("grant", grant, eg);
    chk("sel", sel, model_sel());
    chk("credit_err", credit_err, m_err);
    @(posedge clk);
    model_update(rv, v, d, t, cr);
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, 5'b0, 15'b0, 5'b0, 5'b0);
  endtask

  initial begin : main
    int exp_sel_e [8] = '{7, 0, 7, 1, 7, 3, 7, 0};
    int exp_g2    [8] = '{0, 1, 0, 2, 0, 8, 0, 1};
    int exp_gw    [9] = '{0, 1, 1, 0, 0, 1, 0, 1, 0};
    int exp_sel_n [9] = '{7, 4, 4, 4, 4, 4, 4, 4, 7};
    int rem;
    logic [4:0] cr;
    int pk_rem  [5];
    int pk_dest [5];
    int pk_life [5];

    rst = 1'b0; in_valid = '0; in_dest = '0; in_tail = '0; credit_ret = '0;
    repeat (2) @(posedge clk);
    model_update(1'b0, 5'b0, 15'b0, 5'b0, 5'b0);

    // 1: reset state, single-flit L->E
    do_reset();
    chk("rst_sel", obs_sel, 15'h7fff);
    chk("rst_grant", obs_grant, 5'b0);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    chk("idle_sel", obs_sel, 15'h7fff);
    drive_cycle(1'b1, 5'b00001, dst(2,0,0,0,0), 5'b00001, 5'b0);
    chk("t1_req_grant", obs_grant, 5'b0);
    drive_cycle(1'b1, 5'b00001, dst(2,0,0,0,0), 5'b00001, 5'b0);
    chk("t1_sel_e", obs_sel[8:6], 0);
    chk("t1_grant", obs_grant, 5'b00001);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    chk("t1_sel_e_idle", obs_sel[8:6], 7);

    // 2: L,N,S contend for E
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cr = (m_credit[2] < DEPTH) ? 5'b00100 : 5'b0;
      drive_cycle(1'b1, 5'b01011, dst(2,2,0,2,0), 5'b01011, cr);
      chk("t2_sel_e", obs_sel[8:6], exp_sel_e[c]);
      chk("t2_grant", obs_grant, exp_g2[c]);
    end

    // 3: drain N to 2 credits, then 4-flit W->N stalls on credits
    do_reset();
    for (int c = 0; c < 4; c++)
      drive_cycle(1'b1, 5'b00001, dst(1,0,0,0,0), 5'b00001, 5'b0);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    rem = 4;
    for (int w = 0; w < 9; w++) begin
      cr = (w == 4 || w == 6) ? 5'b00010 : 5'b0;
      drive_cycle(1'b1, (rem > 0) ? 5'b10000 : 5'b0, dst(0,0,0,0,1),
                  (rem == 1) ? 5'b10000 : 5'b0, cr);
      chk("t3_grant_w", obs_grant[4], exp_gw[w]);
      chk("t3_sel_n", obs_sel[5:3], exp_sel_n[w]);
      if (obs_grant[4]) rem--;
    end

    // 4: grant+return cancel, then overflow sets sticky error
    do_reset();
    drive_cycle(1'b1, 5'b00001, dst(2,0,0,0,0), 5'b00001, 5'b0);
    drive_cycle(1'b1, 5'b00001, dst(2,0,0,0,0), 5'b00001, 5'b00100);
    chk("t4_grant", obs_grant, 5'b00001);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b00100);
    chk("t4_err_before", obs_err, 1'b0);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    chk("t4_err_set", obs_err, 1'b1);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    chk("t4_err_held", obs_err, 1'b1);
    do_reset();
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    chk("t4_err_cleared", obs_err, 1'b0);

    // 5: disjoint packets in parallel; dest 6 never served
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, (c < 2) ? 5'b00111 : 5'b00010, dst(3,6,4,0,0), 5'b00111, 5'b0);
      chk("t5_grant_n", obs_grant[1], 1'b0);
      chk("t5_sel_lne", obs_sel[8:0], 9'h1ff);
      if (c == 1) begin
        chk("t5_grant", obs_grant, 5'b00101);
        chk("t5_sel_s", obs_sel[11:9], 0);
        chk("t5_sel_w", obs_sel[14:12], 2);
      end
    end

    // 6: reset mid-packet
    do_reset();
    for (int c = 0; c < 3; c++)
      drive_cycle(1'b1, 5'b10000, dst(0,0,0,0,2), 5'b0, 5'b0);
    drive_cycle(1'b0, 5'b10000, dst(0,0,0,0,2), 5'b0, 5'b0);
    chk("t6_rst_grant", obs_grant, 5'b0);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);
    chk("t6_sel", obs_sel, 15'h7fff);
    chk("t6_grant", obs_grant, 5'b0);
    drive_cycle(1'b1, 5'b10011, dst(2,2,0,0,2), 5'b10011, 5'b0);
    drive_cycle(1'b1, 5'b10011, dst(2,2,0,0,2), 5'b10011, 5'b0);
    chk("t6_sel_e", obs_sel[8:6], 0);
    chk("t6_first", obs_grant, 5'b00001);
    drive_cycle(1'b1, 5'b0, 15'b0, 5'b0, 5'b0);

    // random packets
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pk_rem[i] = 0; pk_dest[i] = 0; pk_life[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       rv;
      logic [4:0] v, t, eg;
      logic [14:0] d;
      rv = ($urandom_range(0, 599) != 0);
      v = '0; t = '0; d = '0; cr = '0;
      for (int i = 0; i < 5; i++) begin
        if (pk_rem[i] == 0 && $urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(0, 19);
          pk_rem[i]  = $urandom_range(1, 4);
          pk_dest[i] = (r < 18) ? (r % 5) : (5 + (r - 18) * 2);
          pk_life[i] = 4;
        end
        if (pk_rem[i] > 0) begin
          v[i]       = ($urandom_range(0, 4) != 0);
          d[3*i +: 3] = 3'(pk_dest[i]);
          t[i]       = (pk_rem[i] == 1);
        end else begin
          d[3*i +: 3] = 3'($urandom_range(0, 7));
          t[i]       = 1'($urandom_range(0, 1));
        end
      end
      for (int o = 0; o < 5; o++)
        cr[o] = (m_credit[o] < DEPTH) && ($urandom_range(0, 2) == 0);
      eg = rv ? model_grant(v) : 5'b0;
      drive_cycle(rv, v, d, t, cr);
      for (int i = 0; i < 5; i++) begin
        if (!rv) pk_rem[i] = 0;
        else if (eg[i]) pk_rem[i]--;
        else if (pk_rem[i] > 0 && pk_dest[i] > 4) begin
          pk_life[i]--;
          if (pk_life[i] == 0) pk_rem[i] = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
